// File: rtl/flags_update.sv
// flags_update: one-stage EFLAGS producer. Computes status/control flag changes,
// forwards its own pending write, enforces CPL/IOPL on IF/IOPL, and drives the STI shadow.
module flags_update (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [3:0]  op,
  input  logic [1:0]  size,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [1:0]  cpl,
  input  logic [31:0] eflags_in,
  output logic        write_enable,
  output logic [31:0] write_data,
  output logic [31:0] write_mask,
  output logic        write_IOPL_enable,
  output logic [1:0]  write_IOPL_data,
  output logic        gp_fault,
  output logic        int_shadow
);
  localparam logic [3:0] OP_ADD = 4'd0,  OP_ADC = 4'd1,  OP_SUB = 4'd2,  OP_SBB = 4'd3,
                         OP_LOGIC = 4'd4, OP_INC = 4'd5, OP_DEC = 4'd6,  OP_POPF = 4'd7,
                         OP_CLC = 4'd8,  OP_STC = 4'd9,  OP_CMC = 4'd10, OP_CLD = 4'd11,
                         OP_STD = 4'd12, OP_CLI = 4'd13, OP_STI = 4'd14;

  logic        we_q, we_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] wmask_q, wmask_d;
  logic        iopl_en_q, iopl_en_d;
  logic [1:0]  iopl_q, iopl_d;
  logic        gp_q, gp_d;
  logic        shadow_q, shadow_d;
  logic        armed_q, armed_d;

  // Effective flags: committed image overlaid with our own write still in flight.
  logic [31:0] f;
  always_comb begin
    f = eflags_in;
    if (we_q) f = (eflags_in & ~wmask_q) | (wdata_q & wmask_q);
    if (iopl_en_q) f[13:12] = iopl_q;
  end

  logic priv_ok;
  assign priv_ok = (cpl <= f[13:12]);

  logic [31:0] wmsk, opb, r, arith_f;
  logic [32:0] sum;
  logic        is_sub, is_logic, cin, cout, msb_a, msb_b, msb_r, of;
  always_comb begin
    case (size)
      2'b00:   wmsk = 32'h0000_00FF;
      2'b01:   wmsk = 32'h0000_FFFF;
      default: wmsk = 32'hFFFF_FFFF;
    endcase
    is_sub   = (op == OP_SUB) || (op == OP_SBB) || (op == OP_DEC);
    is_logic = (op == OP_LOGIC);
    opb      = ((op == OP_INC) || (op == OP_DEC)) ? 32'd1 : b;
    cin      = ((op == OP_ADC) || (op == OP_SBB)) && f[0];
    // Operands are zero-extended to width w, so bit w of the sum is carry/borrow out.
    if (is_sub) sum = {1'b0, a & wmsk} - {1'b0, opb & wmsk} - {32'd0, cin};
    else        sum = {1'b0, a & wmsk} + {1'b0, opb & wmsk} + {32'd0, cin};
    r = is_logic ? (a & wmsk) : (sum[31:0] & wmsk);
    case (size)
      2'b00:   begin cout = sum[8];  msb_a = a[7];  msb_b = opb[7];  msb_r = r[7];  end
      2'b01:   begin cout = sum[16]; msb_a = a[15]; msb_b = opb[15]; msb_r = r[15]; end
      default: begin cout = sum[32]; msb_a = a[31]; msb_b = opb[31]; msb_r = r[31]; end
    endcase
    of = is_sub ? ((msb_a != msb_b) && (msb_r != msb_a))
                : ((msb_a == msb_b) && (msb_r != msb_a));
    arith_f     = '0;
    arith_f[0]  = cout & ~is_logic;
    arith_f[2]  = ~^r[7:0];
    arith_f[4]  = (a[4] ^ opb[4] ^ r[4]) & ~is_logic;
    arith_f[6]  = (r == 32'd0);
    arith_f[7]  = msb_r;
    arith_f[11] = of & ~is_logic;
  end

  logic [31:0] new_f;
  logic        sti_set;
  always_comb begin
    we_d      = 1'b0;
    wmask_d   = '0;
    new_f     = '0;
    iopl_en_d = 1'b0;
    iopl_d    = 2'b00;
    gp_d      = 1'b0;
    if (in_valid) begin
      case (op)
        OP_ADD, OP_ADC, OP_SUB, OP_SBB, OP_LOGIC: begin
          we_d = 1'b1; wmask_d = 32'h0000_08D5; new_f = arith_f;
        end
        OP_INC, OP_DEC: begin
          we_d = 1'b1; wmask_d = 32'h0000_08D4; new_f = arith_f;
        end
        OP_POPF: begin
          // IF follows the popped image only when privileged enough; otherwise it is kept.
          we_d      = 1'b1;
          wmask_d   = priv_ok ? 32'h0000_4FD5 : 32'h0000_4DD5;
          new_f     = a;
          iopl_en_d = (cpl == 2'd0);
          iopl_d    = (cpl == 2'd0) ? a[13:12] : 2'b00;
        end
        OP_CLC, OP_STC, OP_CMC: begin
          we_d = 1'b1; wmask_d = 32'h0000_0001;
          new_f[0] = (op == OP_STC) || ((op == OP_CMC) && !f[0]);
        end
        OP_CLD, OP_STD: begin
          we_d = 1'b1; wmask_d = 32'h0000_0400; new_f[10] = (op == OP_STD);
        end
        OP_CLI, OP_STI: begin
          if (priv_ok) begin
            we_d = 1'b1; wmask_d = 32'h0000_0200; new_f[9] = (op == OP_STI);
          end else begin
            gp_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
    wdata_d = '0;
    if (we_d) begin
      wdata_d = (f & ~wmask_d) | (new_f & wmask_d);
      wdata_d[13:12] = iopl_en_d ? iopl_d : f[13:12];
    end
    // Shadow covers the STI output cycle and the output cycle of the next valid instruction.
    sti_set = in_valid && (op == OP_STI) && priv_ok && !f[9];
    if (in_valid) begin
      shadow_d = sti_set || armed_q;
      armed_d  = sti_set;
    end else begin
      shadow_d = armed_q;
      armed_d  = armed_q;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      we_q      <= 1'b0;
      wdata_q   <= '0;
      wmask_q   <= '0;
      iopl_en_q <= 1'b0;
      iopl_q    <= 2'b00;
      gp_q      <= 1'b0;
      shadow_q  <= 1'b0;
      armed_q   <= 1'b0;
    end else begin
      we_q      <= we_d;
      wdata_q   <= wdata_d;
      wmask_q   <= wmask_d;
      iopl_en_q <= iopl_en_d;
      iopl_q    <= iopl_d;
      gp_q      <= gp_d;
      shadow_q  <= shadow_d;
      armed_q   <= armed_d;
    end
  end

  assign write_enable      = we_q;
  assign write_data        = wdata_q;
  assign write_mask        = wmask_q;
  assign write_IOPL_enable = iopl_en_q;
  assign write_IOPL_data   = iopl_q;
  assign gp_fault          = gp_q;
  assign int_shadow        = shadow_q;
endmodule

// File: tb/tb_flags_update.sv
// Bench for flags_update: arithmetic reference model plus an emulated flags register,
// checked every cycle, with hand-computed literal checks on directed vectors.
module tb_flags_update;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, in_valid;
  logic [3:0]  op;
  logic [1:0]  size, cpl;
  logic [31:0] a, b, eflags_in;
  logic        write_enable, write_IOPL_enable, gp_fault, int_shadow;
  logic [31:0] write_data, write_mask;
  logic [1:0]  write_IOPL_data;

  flags_update dut (
    .clock(clk), .reset(rst_n), .in_valid(in_valid), .op(op), .size(size),
    .a(a), .b(b), .cpl(cpl), .eflags_in(eflags_in),
    .write_enable(write_enable), .write_data(write_data), .write_mask(write_mask),
    .write_IOPL_enable(write_IOPL_enable), .write_IOPL_data(write_IOPL_data),
    .gp_fault(gp_fault), .int_shadow(int_shadow)
  );

  typedef struct packed {
    logic        we;
    logic [31:0] wd;
    logic [31:0] wm;
    logic        ie;
    logic [1:0]  id;
    logic        gp;
    logic        sh;
  } out_t;

  out_t        exp_o = '0;
  logic [31:0] flags_reg = 32'h0000_0002;
  int          shadow_left = 0;
  int          total = 0, passed = 0;
  bit          chk_en = 1'b0;
  assign eflags_in = flags_reg;

  // Expected write from the architectural rules, using signed/unsigned integer arithmetic.
  function automatic out_t model(input logic v, input logic [3:0] o, input logic [1:0] sz,
                                 input logic [31:0] ia, input logic [31:0] ib,
                                 input logic [1:0] c, input logic [31:0] f);
    out_t e;
    longint m, ua, ub, sa, sb, tot, st, rr, cinv;
    logic [31:0] nf, msk;
    logic [7:0]  lo;
    bit priv;
    e = '0;
    nf = '0;
    msk = '0;
    if (!v || o == 4'd15) return e;
    m = longint'(1) << ((sz == 2'd0) ? 8 : (sz == 2'd1) ? 16 : 32);
    priv = (c <= f[13:12]);
    if (o <= 4'd6) begin
      ua = longint'({32'd0, ia}) % m;
      ub = (o == 4'd5 || o == 4'd6) ? 1 : longint'({32'd0, ib}) % m;
      cinv = ((o == 4'd1 || o == 4'd3) && f[0]) ? 1 : 0;
      sa = (ua >= m / 2) ? ua - m : ua;
      sb = (ub >= m / 2) ? ub - m : ub;
      if (o == 4'd2 || o == 4'd3 || o == 4'd6) begin
        tot = ua - ub - cinv; st = sa - sb - cinv; nf[0] = (tot < 0);
      end else if (o == 4'd4) begin
        tot = ua; st = sa; nf[0] = 1'b0;
      end else begin
        tot = ua + ub + cinv; st = sa + sb + cinv; nf[0] = (tot >= m);
      end
      rr = ((tot % m) + m) % m;
      lo = rr[7:0];
      nf[2]  = ($countones(lo) % 2) == 0;
      nf[4]  = (o != 4'd4) && ((((ua >> 4) ^ (ub >> 4) ^ (rr >> 4)) & 1) != 0);
      nf[6]  = (rr == 0);
      nf[7]  = (rr >= m / 2);
      nf[11] = (o != 4'd4) && (st >= m / 2 || st < -(m / 2));
      msk = (o == 4'd5 || o == 4'd6) ? 32'h08D4 : 32'h08D5;
    end else if (o == 4'd7) begin
      nf = ia;
      msk = 32'h4DD5 | (priv ? 32'h0200 : 32'h0);
      e.ie = (c == 2'd0);
      e.id = ia[13:12];
    end else if (o <= 4'd10) begin
      msk = 32'h1;
      nf[0] = (o == 4'd9) ? 1'b1 : (o == 4'd10) ? ~f[0] : 1'b0;
    end else if (o <= 4'd12) begin
      msk = 32'h400;
      nf[10] = (o == 4'd12);
    end else begin
      if (!priv) begin e.gp = 1'b1; return e; end
      msk = 32'h200;
      nf[9] = (o == 4'd14);
    end
    e.we = 1'b1;
    e.wm = msk;
    e.wd = (f & ~msk) | (nf & msk);
    e.wd[13:12] = e.ie ? e.id : f[13:12];
    if (!e.ie) e.id = 2'b00;
    return e;
  endfunction

  // Model stepping and the emulated flags register, both driven from expected values only.
  always @(posedge clk) begin : model_p
    logic [31:0] f;
    out_t n;
    bit sti_sh;
    f = flags_reg;
    if (exp_o.we) f = (f & ~exp_o.wm) | (exp_o.wd & exp_o.wm);
    if (exp_o.ie) f[13:12] = exp_o.id;
    if (!rst_n) begin
      n = '0;
      shadow_left <= 0;
    end else begin
      n = model(in_valid, op, size, a, b, cpl, f);
      sti_sh = in_valid && op == 4'd14 && !n.gp && !f[9];
      if (in_valid) begin
        n.sh = sti_sh || (shadow_left > 0);
        shadow_left <= sti_sh ? 1 : 0;
      end else begin
        n.sh = (shadow_left > 0);
      end
    end
    flags_reg <= f;
    exp_o <= n;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act === expv) passed++;
    else $display("FAIL %s: got %h, expected %h", name, act, expv);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("we", 32'(write_enable), 32'(exp_o.we));
      chk("gp_fault", 32'(gp_fault), 32'(exp_o.gp));
      chk("int_shadow", 32'(int_shadow), 32'(exp_o.sh));
      chk("iopl_en", 32'(write_IOPL_enable), 32'(exp_o.ie));
      if (exp_o.we) begin
        chk("data", write_data, exp_o.wd);
        chk("mask", write_mask, exp_o.wm);
      end
      if (exp_o.ie) chk("iopl_data", 32'(write_IOPL_data), 32'(exp_o.id));
    end
  end

  task automatic issue(input logic [3:0] o, input logic [1:0] sz,
                       input logic [31:0] ia, input logic [31:0] ib);
    in_valid = 1'b1; op = o; size = sz; a = ia; b = ib;
    @(negedge clk);
  endtask

  task automatic idle();
    in_valid = 1'b0; op = 4'd15;
    @(negedge clk);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_we"}, 32'(write_enable), 32'd0);
    chk({tag, "_data"}, write_data, 32'd0);
    chk({tag, "_mask"}, write_mask, 32'd0);
    chk({tag, "_ie"}, 32'(write_IOPL_enable), 32'd0);
    chk({tag, "_id"}, 32'(write_IOPL_data), 32'd0);
    chk({tag, "_gp"}, 32'(gp_fault), 32'd0);
    chk({tag, "_sh"}, 32'(int_shadow), 32'd0);
  endtask

  logic [3:0]  vo[8]  = '{4'd0, 4'd2, 4'd1, 4'd3, 4'd5, 4'd6, 4'd4, 4'd0};
  logic [1:0]  vs[8]  = '{2'd1, 2'd0, 2'd2, 2'd1, 2'd1, 2'd2, 2'd0, 2'd3};
  logic [31:0] va[8]  = '{32'h7FFF, 32'h05, 32'h7FFF_FFFF, 32'h8000, 32'hFFFF, 32'h0, 32'h1234_5680, 32'hFFFF_FFFF};
  logic [31:0] vb[8]  = '{32'h0001, 32'h07, 32'h0000_0001, 32'h0001, 32'h0, 32'h0, 32'h0, 32'h1};

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; op = 4'd15; size = 2'd0; a = '0; b = '0; cpl = 2'd0;
    @(negedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1;

    issue(4'd0, 2'd0, 32'hFF, 32'h01);           // 8-bit ADD FF+01
    chk("add8_mask", write_mask, 32'h08D5);
    chk("add8_data", write_data, 32'h0000_0057);
    chk("model_add8", exp_o.wd & 32'h08D5, 32'h055);
    issue(4'd2, 2'd2, 32'h8000_0000, 32'h1);     // 32-bit SUB
    chk("sub32_flags", write_data & 32'h08D5, 32'h814);
    issue(4'd9, 2'd0, 32'h0, 32'h0);             // STC
    issue(4'd1, 2'd1, 32'hFFFF, 32'h0);          // ADC uses forwarded CF
    chk("adc16_flags", write_data & 32'h08D5, 32'h055);
    chk("model_adc16", exp_o.wd & 32'h08D5, 32'h055);
    issue(4'd5, 2'd0, 32'h7F, 32'h0);            // INC keeps CF
    chk("inc8_mask", write_mask, 32'h08D4);
    chk("inc8_flags", write_data & 32'h08D5, 32'h891);
    issue(4'd6, 2'd1, 32'h0, 32'h0);             // DEC
    issue(4'd4, 2'd2, 32'h0, 32'h0);             // LOGIC zero result
    chk("logic_flags", write_data & 32'h08D5, 32'h044);
    issue(4'd9, 2'd0, 32'h0, 32'h0);
    issue(4'd3, 2'd0, 32'h10, 32'h0F);           // SBB with CF=1
    chk("sbb8_flags", write_data & 32'h08D5, 32'h054);
    issue(4'd10, 2'd0, 32'h0, 32'h0);            // CMC
    issue(4'd1, 2'd0, 32'h0, 32'h0);
    issue(4'd12, 2'd0, 32'h0, 32'h0);            // STD
    chk("std_df", 32'(write_data[10]), 32'd1);
    issue(4'd11, 2'd0, 32'h0, 32'h0);            // CLD

    cpl = 2'd3;
    issue(4'd13, 2'd0, 32'h0, 32'h0);            // CLI faults at cpl 3, IOPL 0
    chk("cli_gp", 32'(gp_fault), 32'd1);
    chk("cli_gp_we", 32'(write_enable), 32'd0);
    idle();
    chk("gp_pulse_end", 32'(gp_fault), 32'd0);
    issue(4'd7, 2'd0, 32'h3200, 32'h0);          // POPF at cpl 3
    chk("popf3_ie", 32'(write_IOPL_enable), 32'd0);
    chk("popf3_iopl", 32'(write_data[13:12]), 32'd0);
    chk("popf3_if", 32'(write_data[9]), 32'd0);
    chk("popf3_mask", write_mask, 32'h4DD5);
    cpl = 2'd0;
    issue(4'd7, 2'd0, 32'h3200, 32'h0);          // POPF at cpl 0
    chk("popf0_ie", 32'(write_IOPL_enable), 32'd1);
    chk("popf0_id", 32'(write_IOPL_data), 32'd3);
    chk("popf0_iopl", 32'(write_data[13:12]), 32'd3);
    chk("popf0_if", 32'(write_data[9]), 32'd1);
    cpl = 2'd3;
    issue(4'd13, 2'd0, 32'h0, 32'h0);            // CLI allowed via forwarded IOPL 3
    chk("cli3_we", 32'(write_enable), 32'd1);
    chk("cli3_if", 32'(write_data[9]), 32'd0);
    issue(4'd14, 2'd0, 32'h0, 32'h0);            // STI with IF=0
    chk("sti_sh", 32'(int_shadow), 32'd1);
    issue(4'd0, 2'd0, 32'h1, 32'h1);
    chk("add1_sh", 32'(int_shadow), 32'd1);
    issue(4'd0, 2'd0, 32'h1, 32'h1);
    chk("add2_sh", 32'(int_shadow), 32'd0);
    issue(4'd14, 2'd0, 32'h0, 32'h0);            // STI with IF already 1
    chk("sti_if1_sh", 32'(int_shadow), 32'd0);
    issue(4'd13, 2'd0, 32'h0, 32'h0);
    issue(4'd14, 2'd0, 32'h0, 32'h0);
    idle();
    idle();
    chk("sh_hold_idle", 32'(int_shadow), 32'd1);
    issue(4'd15, 2'd0, 32'h0, 32'h0);            // NOP consumes the shadow
    chk("nop_sh", 32'(int_shadow), 32'd1);
    chk("nop_we", 32'(write_enable), 32'd0);
    idle();
    chk("sh_clear", 32'(int_shadow), 32'd0);
    cpl = 2'd0;

    for (int i = 0; i < 8; i++) issue(vo[i], vs[i], va[i], vb[i]);
    chk("add32w_flags", write_data & 32'h08D5, 32'h055);

    issue(4'd0, 2'd0, 32'h1, 32'h2);
    chk("pre_rst_we", 32'(write_enable), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    chk_zero("midrst");
    rst_n = 1'b1;
    idle();
    chk("post_rst_we", 32'(write_enable), 32'd0);
    idle();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/flags_update.md
# flags_update

Flags-producing stage directly upstream of the EFLAGS register. Accepts one retired instruction per cycle: ALU operands, operation class and operand size. Computes the architectural status flags, or the control-flag change, merges them with the current EFLAGS, and drives the register's write port one cycle later. It also forwards its own pending write so back-to-back flag consumers (ADC, SBB, CMC, CLI/STI checks) see correct values. It enforces the CPL/IOPL rules for IF and IOPL writes and generates the STI interrupt shadow.

## Interface
- No parameters.
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-low; 0 at a rising edge resets the block
- in_valid  in  1  instruction presented this cycle
- op  in  4  0 ADD, 1 ADC, 2 SUB/CMP, 3 SBB, 4 LOGIC, 5 INC, 6 DEC, 7 POPF, 8 CLC, 9 STC, 10 CMC, 11 CLD, 12 STD, 13 CLI, 14 STI, 15 NOP
- size  in  2  00 = 8-bit, 01 = 16-bit, 10 = 32-bit; 11 treated as 32-bit
- a, b  in  32  operands; for LOGIC, a is the logic result; for POPF, a is the popped image
- cpl  in  2  current privilege level
- eflags_in  in  32  committed EFLAGS, read back from the flags register
- write_enable  out  1  write strobe toward the flags register
- write_data  out  32  full merged EFLAGS image
- write_mask  out  32  bits changed by this write
- write_IOPL_enable  out  1  IOPL update strobe
- write_IOPL_data  out  2  new IOPL
- gp_fault  out  1  one-cycle privilege-violation pulse
- int_shadow  out  1  inhibit interrupt recognition

## Operation
- Bit positions: CF 0, PF 2, AF 4, ZF 6, SF 7, TF 8, IF 9, DF 10, OF 11, IOPL 13:12, NT 14.
- The effective flags value F is eflags_in, overlaid with the registered pending write when one is outstanding: (eflags_in & ~mask) | (data & mask), with IOPL taken from write_IOPL_data if write_IOPL_enable is set.
- Width w comes from size. Result r = low w bits.
  - ADD/ADC: r = a + b + cin, where cin = F.CF for ADC, else 0.
  - SUB/SBB: r = a − b − borrow, where borrow = F.CF for SBB, else 0.
  - INC/DEC: b = 1, cin = 0.
- Flags for arithmetic ops:
  - CF = carry (add) or borrow (sub) out of bit w−1.
  - AF = a[4]^b[4]^r[4].
  - ZF = (r == 0).
  - SF = r[w−1].
  - PF = even parity of r[7:0].
  - OF (add) = (a[w−1]==b[w−1]) && (r[w−1]!=a[w−1]).
  - OF (sub) = (a[w−1]!=b[w−1]) && (r[w−1]!=a[w−1]).
- Masks by op:
  - ADD/ADC/SUB/SBB: mask 0x08D5.
  - INC/DEC: mask 0x08D4; CF is preserved.
  - LOGIC: r = a, CF = OF = AF = 0, mask 0x08D5.
- CLC/STC/CMC: mask 0x1; CMC writes ~F.CF.
- CLD/STD: mask 0x400.
- CLI/STI:
  - If cpl ≤ F.IOPL: mask 0x200.
  - Otherwise: no write, gp_fault = 1.
- POPF:
  - Base mask 0x4DD5.
  - Bit 9 is added to the mask only if cpl ≤ F.IOPL; otherwise IF silently retains its value.
  - If cpl == 0: write_IOPL_enable = 1 and write_IOPL_data = a[13:12]; otherwise IOPL is unchanged.
  - RF and VM are never written.
- NOP and in_valid = 0: no write.
- write_data = (F & ~mask) | (new & mask). The IOPL bits in write_data always equal the IOPL being committed.
- int_shadow:
  - Set when an STI commits while F.IF was 0.
  - Stays high until the output cycle of the next valid instruction, inclusive.
  - Then clears.

## Timing
- One stage: an instruction accepted at edge N drives its outputs during cycle N+1, for exactly one cycle. The flags register captures at edge N+1, so eflags_in reflects it from N+2.
- Throughput is one instruction per cycle. There is no backpressure.
- Forwarding covers the gap: an instruction at edge N+1 uses the pending write from N, never the stale eflags_in.
- All outputs are registered.
- Reset values are 0 for every output: write_enable, write_data, write_mask, write_IOPL_enable, write_IOPL_data, gp_fault and int_shadow.
- Reset mid-stream discards the pending write; no write issues on the cycle after reset.
- A faulting CLI/STI produces gp_fault at N+1 with write_enable = 0, and is not forwarded.

## Test plan
- 8-bit ADD a = 0xFF, b = 0x01 -> next cycle write_enable = 1, mask 0x08D5, CF = 1, ZF = 1, AF = 1, PF = 1, SF = 0, OF = 0.
- 32-bit SUB a = 0x80000000, b = 1 -> OF = 1, SF = 0, CF = 0, r = 0x7FFFFFFF.
- STC immediately followed by ADC 16-bit a = 0xFFFF, b = 0 (eflags_in still CF = 0) -> ADC uses forwarded CF = 1: r = 0, CF = 1, ZF = 1.
- cpl = 3, IOPL = 0, CLI -> gp_fault pulse, write_enable = 0. POPF a = 0x3200 at cpl = 3 -> IF and IOPL unchanged, write_IOPL_enable = 0. The same POPF at cpl = 0 -> IOPL = 3, IF = 1.
- With IF = 0, STI then ADD then ADD -> int_shadow is high from the STI output cycle through the first ADD's output cycle, and low for the second.
- reset low for one cycle, asserted while an ADD is pending -> all outputs 0 the next cycle, no write issued.
